// File: rtl/gfx_sched_mbox.sv
// gfx_sched_mbox: AXI-lite slave mailbox for the scheduler core.
// Buffers host doorbell words in a FIFO, holds one scheduler reply for the
// host, and drives the scheduler irq lines from masked pending bits.
// Optional build macro GFX_SCHED_MBOX_TIMESTAMP_EN adds a free-running cycle
// counter readable at offset 0x14. Without it, offset 0x14 reads 0.
module gfx_sched_mbox #(
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 axis_awvalid,
  output logic                 axis_awready,
  input  logic [ADDR_BITS-1:0] axis_awaddr,
  input  logic                 axis_wvalid,
  output logic                 axis_wready,
  input  logic [31:0]          axis_wdata,
  input  logic [3:0]           axis_wstrb,
  output logic                 axis_bvalid,
  input  logic                 axis_bready,
  input  logic                 axis_arvalid,
  output logic                 axis_arready,
  input  logic [ADDR_BITS-1:0] axis_araddr,
  output logic                 axis_rvalid,
  input  logic                 axis_rready,
  output logic [31:0]          axis_rdata,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [31:0]          host_data,
  output logic                 reply_valid,
  input  logic                 reply_ready,
  output logic [31:0]          reply_data,
  input  logic [29:0]          ext_irq,
  output logic [31:0]          irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_POP    = 3'd1;
  localparam logic [2:0] REG_PEND   = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_REPLY  = 3'd4;
  localparam logic [2:0] REG_TS     = 3'd5;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   pend_reg, pend_next, mask_reg, irq_reg;
  logic [31:0]   reply_reg, rdata_reg, rdata_next;
  logic          reply_valid_reg, underflow_reg, bvalid_reg, rvalid_reg;
  logic [29:0]   ext_hist_reg;
  logic [2:0]    wsel, rsel;
  logic          resp_busy, wr_accept, rd_accept, push, pop, reply_drain, fifo_empty;
  logic [31:0]   set_vec, clr_vec;
  logic          unused_addr_bits;

`ifdef GFX_SCHED_MBOX_TIMESTAMP_EN
  logic [31:0]   ts_reg;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (srst) ts_reg <= '0;
    else      ts_reg <= ts_reg + 32'd1;
  end
`endif

  // Only the word offset within the mailbox window is decoded.
  assign wsel = axis_awaddr[4:2];
  assign rsel = axis_araddr[4:2];
  assign unused_addr_bits = ^{axis_awaddr, axis_araddr};

  // One transaction at a time; a REPLY write waits while the holding
  // register is full unless the host drains it in this very cycle.
  assign resp_busy   = bvalid_reg | rvalid_reg;
  assign reply_drain = reply_valid_reg & reply_ready;
  assign wr_accept   = axis_awvalid & axis_wvalid & ~resp_busy & ~srst &
                       ~((wsel == REG_REPLY) & reply_valid_reg & ~reply_ready);
  assign rd_accept   = axis_arvalid & ~wr_accept & ~resp_busy & ~srst;

  assign axis_awready = wr_accept;
  assign axis_wready  = wr_accept;
  assign axis_arready = rd_accept;
  assign axis_bvalid  = bvalid_reg;
  assign axis_rvalid  = rvalid_reg;
  assign axis_rdata   = rdata_reg;
  assign reply_valid  = reply_valid_reg;
  assign reply_data   = reply_reg;
  assign irq          = irq_reg;

  assign fifo_empty = (count_reg == '0);
  assign host_ready = ~srst & (count_reg < DEPTH_C);
  assign push       = host_valid & host_ready;
  assign pop        = rd_accept & (rsel == REG_POP) & ~fifo_empty;

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pending bits: sets from push, reply drain and ext rising edges beat W1C.
  always_comb begin
    set_vec   = {ext_irq & ~ext_hist_reg, reply_drain, push};
    clr_vec   = (wr_accept && wsel == REG_PEND) ? axis_wdata : 32'h0;
    pend_next = (pend_reg & ~clr_vec) | set_vec;
  end

  // Read data selection, captured into rdata_reg at the ar handshake.
  always_comb begin
    rdata_next = 32'h0;
    case (rsel)
      REG_STATUS: rdata_next = {16'h0, 8'(count_reg), 5'h0, underflow_reg,
                                reply_valid_reg, ~fifo_empty};
      REG_POP:    rdata_next = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];
      REG_PEND:   rdata_next = pend_reg;
      REG_MASK:   rdata_next = mask_reg;
`ifdef GFX_SCHED_MBOX_TIMESTAMP_EN
      REG_TS:     rdata_next = ts_reg;
`endif
      default:    rdata_next = 32'h0;
    endcase
  end

  // Doorbell storage array, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= host_data;
  end

  // Control state: pointers, pending, reply holding, handshake responses.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      pend_reg        <= '0;
      irq_reg         <= '0;
      ext_hist_reg    <= '0;
      reply_reg       <= '0;
      reply_valid_reg <= 1'b0;
      underflow_reg   <= 1'b0;
      bvalid_reg      <= 1'b0;
      rvalid_reg      <= 1'b0;
      rdata_reg       <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg    <= count_next;
      pend_reg     <= pend_next;
      irq_reg      <= pend_reg & mask_reg;
      ext_hist_reg <= ext_irq;

      if (wr_accept && wsel == REG_REPLY) begin
        reply_reg       <= axis_wdata;
        reply_valid_reg <= 1'b1;
      end else if (reply_drain) begin
        reply_valid_reg <= 1'b0;
      end

      if (rd_accept && rsel == REG_STATUS)
        underflow_reg <= 1'b0;
      else if (rd_accept && rsel == REG_POP && fifo_empty)
        underflow_reg <= 1'b1;

      if (wr_accept)        bvalid_reg <= 1'b1;
      else if (axis_bready) bvalid_reg <= 1'b0;

      if (rd_accept) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rdata_next;
      end else if (axis_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Mask register with per-byte write strobes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask_byte
    always_ff @(posedge clk) begin
      if (srst)
        mask_reg[8*gi +: 8] <= 8'h0;
      else if (wr_accept && wsel == REG_MASK && axis_wstrb[gi])
        mask_reg[8*gi +: 8] <= axis_wdata[8*gi +: 8];
    end
  end

endmodule

// File: tb/tb_gfx_sched_mbox.sv
// Testbench for gfx_sched_mbox: directed scenarios followed by random
// operations, all checked against a queue/array model of the mailbox.
`timescale 1ns/1ps
module tb_gfx_sched_mbox;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        axis_awvalid = 1'b0, axis_awready;
  logic [7:0]  axis_awaddr = '0;
  logic        axis_wvalid = 1'b0, axis_wready;
  logic [31:0] axis_wdata = '0;
  logic [3:0]  axis_wstrb = '0;
  logic        axis_bvalid, axis_bready = 1'b0;
  logic        axis_arvalid = 1'b0, axis_arready;
  logic [7:0]  axis_araddr = '0;
  logic        axis_rvalid, axis_rready = 1'b0;
  logic [31:0] axis_rdata;
  logic        host_valid = 1'b0, host_ready;
  logic [31:0] host_data = '0;
  logic        reply_valid, reply_ready = 1'b0;
  logic [31:0] reply_data;
  logic [29:0] ext_irq = '0;
  logic [31:0] irq;

  always #5 clk = ~clk;

  gfx_sched_mbox #(.ADDR_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst),
    .axis_awvalid(axis_awvalid), .axis_awready(axis_awready), .axis_awaddr(axis_awaddr),
    .axis_wvalid(axis_wvalid), .axis_wready(axis_wready), .axis_wdata(axis_wdata),
    .axis_wstrb(axis_wstrb), .axis_bvalid(axis_bvalid), .axis_bready(axis_bready),
    .axis_arvalid(axis_arvalid), .axis_arready(axis_arready), .axis_araddr(axis_araddr),
    .axis_rvalid(axis_rvalid), .axis_rready(axis_rready), .axis_rdata(axis_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .reply_data(reply_data),
    .ext_irq(ext_irq), .irq(irq)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model
  logic [31:0] fifo_q[$];
  logic [31:0] pend_m = '0, mask_m = '0, reply_m = '0;
  logic        reply_v_m = 1'b0, underflow_m = 1'b0;
  logic [29:0] ext_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    logic nonempty;
    nonempty = (fifo_q.size() != 0);
    return {16'h0, 8'(fifo_q.size()), 5'h0, underflow_m, reply_v_m, nonempty};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok;
    ok = 1'b0;
    axis_awaddr = addr; axis_wdata = data; axis_wstrb = strb;
    axis_awvalid = 1'b1; axis_wvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = axis_awready && axis_wready;
      cyc();
    end
    axis_awvalid = 1'b0; axis_wvalid = 1'b0;
    check("aw_w_handshake", 32'(ok), 32'd1);
    @(negedge clk);
    check("bvalid_after_write", 32'(axis_bvalid), 32'd1);
    axis_bready = 1'b1; cyc(); axis_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    bit ok;
    ok = 1'b0;
    axis_araddr = addr; axis_arvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = axis_arready;
      cyc();
    end
    axis_arvalid = 1'b0;
    check("ar_handshake", 32'(ok), 32'd1);
    @(negedge clk);
    check("rvalid_after_read", 32'(axis_rvalid), 32'd1);
    data = axis_rdata;
    axis_rready = 1'b1; cyc(); axis_rready = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] d);
    bit exp_ready;
    host_data = d; host_valid = 1'b1;
    @(negedge clk);
    exp_ready = (fifo_q.size() < DEPTH);
    check("host_ready", 32'(host_ready), 32'(exp_ready));
    cyc(); host_valid = 1'b0;
    if (exp_ready) begin
      fifo_q.push_back(d);
      pend_m[0] = 1'b1;
    end
    cyc();
  endtask

  task automatic do_pop(input string tag);
    logic [31:0] d, exp;
    if (fifo_q.size() != 0) exp = fifo_q.pop_front();
    else begin exp = 32'h0; underflow_m = 1'b1; end
    axi_read(8'h04, d);
    check(tag, d, exp);
  endtask

  task automatic do_status(input string tag);
    logic [31:0] d, exp;
    exp = status_m();
    axi_read(8'h00, d);
    underflow_m = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic do_read_expect(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic do_mask_write(input logic [31:0] d, input logic [3:0] strb);
    axi_write(8'h0C, d, strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) mask_m[8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_pend_w1c(input logic [31:0] d);
    axi_write(8'h08, d, 4'hF);
    pend_m = pend_m & ~d;
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    check(tag, irq, pend_m & mask_m);
    cyc();
  endtask

  initial begin
    logic [31:0] rnd;
    logic [29:0] new_ext;

    // Reset: ready outputs must stay low even with requests asserted.
    axis_awvalid = 1'b1; axis_wvalid = 1'b1; axis_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(axis_awready), 32'd0);
    check("rst_wready", 32'(axis_wready), 32'd0);
    check("rst_arready", 32'(axis_arready), 32'd0);
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_bvalid", 32'(axis_bvalid), 32'd0);
    check("rst_rvalid", 32'(axis_rvalid), 32'd0);
    check("rst_rdata", axis_rdata, 32'd0);
    check("rst_reply_valid", 32'(reply_valid), 32'd0);
    check("rst_reply_data", reply_data, 32'd0);
    check("rst_irq", irq, 32'd0);
    axis_awvalid = 1'b0; axis_wvalid = 1'b0; axis_arvalid = 1'b0;
    @(posedge clk); #1; srst = 1'b0;
    @(negedge clk);
    check("post_rst_host_ready", 32'(host_ready), 32'd1);
    cyc();
    do_status("post_rst_status");

    // Three doorbells come back in order; pend[0] latched.
    do_push(32'h11); do_push(32'h22); do_push(32'h33);
    do_pop("pop_11"); do_pop("pop_22"); do_pop("pop_33");
    do_status("status_after_drain");
    do_read_expect("pend_after_push", 8'h08, pend_m);

    // Fill to capacity, one more push refused, then a pop frees a slot.
    for (int i = 0; i < DEPTH; i++) do_push($urandom);
    do_push(32'hDEAD_0001);
    do_status("status_full");
    do_pop("pop_from_full");
    @(negedge clk);
    check("host_ready_after_pop", 32'(host_ready), 32'd1);
    cyc();
    while (fifo_q.size() != 0) do_pop("drain_full");

    // Underflow is sticky until a STATUS read.
    do_pop("pop_empty");
    do_status("status_underflow");
    do_status("status_underflow_cleared");

    // Mask byte strobes and irq latency relative to a push.
    do_mask_write(32'h0000_0003, 4'h1);
    do_pend_w1c(32'hFFFF_FFFF);
    check_irq("irq_cleared");
    host_data = 32'h55; host_valid = 1'b1;
    @(negedge clk);
    check("irq_push_ready", 32'(host_ready), 32'd1);
    cyc(); host_valid = 1'b0;
    fifo_q.push_back(32'h55); pend_m[0] = 1'b1;
    @(negedge clk);
    check("irq_one_cycle_after_push", irq, 32'h0);
    cyc();
    @(negedge clk);
    check("irq_two_cycles_after_push", irq, 32'h1);
    cyc();
    do_pend_w1c(32'h1);
    check_irq("irq_after_w1c");
    do_pop("pop_irq_word");
    do_mask_write(32'hA5C3_0F00, 4'b1010);
    do_read_expect("mask_strobe_bytes", 8'h0C, mask_m);

    // Reply: second REPLY write stalls until the first is drained.
    axi_write(8'h10, 32'hCAFE, 4'hF);
    reply_m = 32'hCAFE; reply_v_m = 1'b1;
    @(negedge clk);
    check("reply_valid_set", 32'(reply_valid), 32'd1);
    check("reply_data_cafe", reply_data, reply_m);
    cyc();
    axis_awaddr = 8'h10; axis_wdata = 32'hBEEF; axis_wstrb = 4'hF;
    axis_awvalid = 1'b1; axis_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reply_write_stalled", 32'(axis_awready), 32'd0);
      cyc();
    end
    reply_ready = 1'b1;
    @(negedge clk);
    check("reply_write_on_drain", 32'(axis_awready & axis_wready), 32'd1);
    check("reply_drain_data", reply_data, 32'hCAFE);
    cyc();
    axis_awvalid = 1'b0; axis_wvalid = 1'b0; reply_ready = 1'b0;
    reply_m = 32'hBEEF; pend_m[1] = 1'b1;
    @(negedge clk);
    check("reply_bvalid", 32'(axis_bvalid), 32'd1);
    check("reply_valid_kept", 32'(reply_valid), 32'd1);
    check("reply_data_beef", reply_data, reply_m);
    axis_bready = 1'b1; cyc(); axis_bready = 1'b0;
    do_read_expect("pend_reply_drain", 8'h08, pend_m);
    do_status("status_reply_busy");
    reply_ready = 1'b1; cyc(); reply_ready = 1'b0;
    reply_v_m = 1'b0;
    @(negedge clk);
    check("reply_valid_cleared", 32'(reply_valid), 32'd0);
    cyc();

    // ext_irq[0] rising edge with a W1C of bit 2 in the same cycle.
    do_mask_write(32'h0000_0004, 4'hF);
    do_pend_w1c(32'hFFFF_FFFF);
    ext_irq = 30'h1;
    axis_awaddr = 8'h08; axis_wdata = 32'h4; axis_wstrb = 4'hF;
    axis_awvalid = 1'b1; axis_wvalid = 1'b1;
    @(negedge clk);
    check("edge_w1c_accept", 32'(axis_awready), 32'd1);
    cyc();
    axis_awvalid = 1'b0; axis_wvalid = 1'b0;
    ext_m = 30'h1; pend_m[2] = 1'b1;
    @(negedge clk);
    check("edge_w1c_bvalid", 32'(axis_bvalid), 32'd1);
    axis_bready = 1'b1; cyc(); axis_bready = 1'b0;
    do_read_expect("pend_set_wins", 8'h08, pend_m);
    check_irq("irq_ext_edge");
    do_pend_w1c(32'h4);
    do_read_expect("pend_set_once", 8'h08, pend_m);
    ext_irq = 30'h0; ext_m = 30'h0;
    cyc();

    // Unmapped and write-only offsets.
    do_read_expect("read_reply_wo", 8'h10, 32'h0);
    do_read_expect("read_unmapped", 8'h18, 32'h0);
`ifndef GFX_SCHED_MBOX_TIMESTAMP_EN
    do_read_expect("read_ts_absent", 8'h14, 32'h0);
`endif
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF);
    do_read_expect("mask_unchanged", 8'h0C, mask_m);
    do_read_expect("status_alias", 8'h03, status_m());

    // Random operations against the model.
    for (int it = 0; it < 150; it++) begin
      rnd = $urandom;
      case ($urandom_range(0, 8))
        0, 1, 2: do_push(rnd);
        3: do_pop("rand_pop");
        4: do_status("rand_status");
        5: do_read_expect("rand_pend", 8'h08, pend_m);
        6: do_mask_write(rnd, 4'($urandom_range(0, 15)));
        7: do_pend_w1c(rnd);
        default: begin
          new_ext = 30'($urandom);
          ext_irq = new_ext;
          pend_m[31:2] = pend_m[31:2] | (new_ext & ~ext_m);
          ext_m = new_ext;
          cyc(); cyc();
        end
      endcase
      check_irq("rand_irq");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
